// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU sequencer states
// and request legality helpers.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return !(f3 inside {F3_SB, F3_SH, F3_SW});
    else
      return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

  // Size lives in funct3[1:0] for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load funct3.
module load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = '0;
    case (byte_off)
      2'd0: sel_b = rdata[7:0];
      2'd1: sel_b = rdata[15:8];
      2'd2: sel_b = rdata[23:16];
      2'd3: sel_b = rdata[31:24];
      default: sel_b = '0;
    endcase
    sel_h = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{24{sel_b[7]}}, sel_b};
      F3_LH:   result = {{16{sel_h[15]}}, sel_h};
      F3_LW:   result = rdata;
      F3_LBU:  result = {24'd0, sel_b};
      F3_LHU:  result = {16'd0, sel_h};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request in flight through IDLE -> ACCESS -> RESP,
// with alignment/range checking, byte-lane store generation and load extension.
module lsu_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_mask,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned AQ_W = ADDR_W + 2;

  lsu_state_e state_q, state_d;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [AQ_W-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            accept;
  logic            req_err;
  logic            store_phase;
  logic [31:0]     load_result;

  assign accept      = (state_q == LSU_IDLE) && req_valid;
  assign store_phase = (state_q == LSU_ACCESS) && we_q;

  // Only the low AQ_W address bits are kept, so range is checked on the live request.
  assign req_err = f3_illegal(req_we, req_funct3)
                 || misaligned(req_funct3, req_addr[1:0])
                 || ((req_addr >> AQ_W) != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:   if (req_valid) state_d = req_err ? LSU_RESP : LSU_ACCESS;
      LSU_ACCESS: state_d = LSU_RESP;
      LSU_RESP:   if (rsp_ready) state_d = LSU_IDLE;
      default:    state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AQ_W-1:0];
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if ((state_q == LSU_ACCESS) && !we_q)
        rdata_q <= load_result;
      if ((state_q == LSU_RESP) && rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  load_align u_load_align (
    .rdata    (mem_rdata),
    .byte_off (addr_q[1:0]),
    .funct3   (f3_q),
    .result   (load_result)
  );

  always_comb begin
    mem_mask  = '0;
    mem_wdata = '0;
    if (store_phase) begin
      case (f3_q[1:0])
        2'b00: begin
          mem_mask  = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_mask  = 4'b0011 << {addr_q[1], 1'b0};
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_mask  = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

  // rst gates the write combinationally so a reset landing in ACCESS cannot commit.
  assign mem_en    = store_phase && !rst;
  assign mem_addr  = addr_q[AQ_W-1:2];
  assign req_ready = (state_q == LSU_IDLE);
  assign rsp_valid = (state_q == LSU_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural word memory beside the DUT.
module tb_lsu_ctrl;
  import rv32i_pkg::*;

  localparam int unsigned ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_mask[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc;
  } rsp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: write port against expected stores, responses against the queue.
  rsp_t cur;
  bit   in_resp = 1'b0;
  always @(negedge clk) begin
    wr_t w;
    if (mem_en) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: mem_en=1 at word 0x%02h, expected mem_en=0", mem_addr);
      end else begin
        w = wr_q.pop_front();
        chk("mem_addr",  32'(mem_addr), 32'(w.addr));
        chk("mem_mask",  32'(mem_mask), 32'(w.mask));
        chk("mem_wdata", mem_wdata, w.wdata);
      end
    end
    if (rsp_valid) begin
      if (!in_resp) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1, expected no response pending");
        end else begin
          cur = rsp_q.pop_front();
          chk("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
        end
      end
      chk("rsp_rdata", rsp_rdata, cur.rdata);
      chk("rsp_err", 32'(rsp_err), 32'(cur.err));
      chk("req_ready_in_resp", 32'(req_ready), 32'd0);
    end
    in_resp = rsp_valid;
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic [3:0] exp_mask,
                       input logic [31:0] exp_mwdata);
    int unsigned n;
    rsp_t r;
    wr_t  w;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: req_ready=0 after %0d cycles, expected 1", n);
      return;
    end
    r.rdata = exp_rdata;
    r.err   = exp_err;
    r.lat   = exp_err ? 1 : 2;
    r.acc   = cyc;
    rsp_q.push_back(r);
    if (we && !exp_err) begin
      w.addr  = addr[9:2];
      w.mask  = exp_mask;
      w.wdata = exp_mwdata;
      wr_q.push_back(w);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while ((rsp_q.size() != 0 || rsp_valid || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(rsp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_mem_en"},    32'(mem_en), 32'd0);
    chk({tag, "_mem_mask"},  32'(mem_mask), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    mem_init = 1'b0;
    rst = 1'b0;

    // we, f3, addr, wdata, exp_rdata, exp_err, exp_mask, exp_mem_wdata
    issue(1'b1, F3_SW,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 4'hF,    32'hDEADBEEF);
    issue(1'b0, F3_LW,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 4'h0,    32'h0);
    issue(1'b1, F3_SB,  32'h13,  32'h000000A5, 32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5);
    issue(1'b0, F3_LB,  32'h13,  32'h0,        32'hFFFFFFA5, 1'b0, 4'h0,    32'h0);
    issue(1'b0, F3_LBU, 32'h13,  32'h0,        32'h000000A5, 1'b0, 4'h0,    32'h0);
    issue(1'b0, F3_LBU, 32'h11,  32'h0,        32'h000000BE, 1'b0, 4'h0,    32'h0);
    issue(1'b1, F3_SH,  32'h22,  32'h00008001, 32'h0,        1'b0, 4'b1100, 32'h80018001);
    issue(1'b0, F3_LH,  32'h22,  32'h0,        32'hFFFF8001, 1'b0, 4'h0,    32'h0);
    issue(1'b0, F3_LHU, 32'h22,  32'h0,        32'h00008001, 1'b0, 4'h0,    32'h0);
    issue(1'b1, F3_SW,  32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 4'hF,    32'hCAFEF00D);
    issue(1'b0, F3_LW,  32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 4'h0,    32'h0);

    // Errored requests: no write expected, rdata 0, one-cycle latency.
    issue(1'b0, F3_LW,  32'h11,  32'h0,        32'h0, 1'b1, 4'h0, 32'h0);
    issue(1'b1, F3_SH,  32'h21,  32'h12345678, 32'h0, 1'b1, 4'h0, 32'h0);
    issue(1'b0, F3_LB,  32'h400, 32'h0,        32'h0, 1'b1, 4'h0, 32'h0);
    issue(1'b0, 3'b011, 32'h10,  32'h0,        32'h0, 1'b1, 4'h0, 32'h0);
    issue(1'b1, 3'b011, 32'h10,  32'h11111111, 32'h0, 1'b1, 4'h0, 32'h0);
    issue(1'b0, 3'b110, 32'h10,  32'h0,        32'h0, 1'b1, 4'h0, 32'h0);
    wait_idle();

    // Backpressure: response held for 5 cycles with rsp_ready low.
    rsp_ready = 1'b0;
    issue(1'b0, F3_LW, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 4'h0, 32'h0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during ACCESS of a store must suppress the write.
    issue(1'b1, F3_SW, 32'h30, 32'h11112222, 32'h0, 1'b0, 4'hF, 32'h11112222);
    wait_idle();
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_SW;
    req_addr   = 32'h30;
    req_wdata  = 32'h33334444;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_access_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_rst");
    issue(1'b0, F3_LW, 32'h30, 32'h0, 32'h11112222, 1'b0, 4'h0, 32'h0);
    wait_idle();

    chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
